// File: rtl/xalu_ctrl_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface xalu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        rd_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  modport master (
    output start, op, A, B, req, rd_sel,
    input  busy, HI, LO, rd_data
  );

  modport slave (
    input  start, op, A, B, req, rd_sel,
    output busy, HI, LO, rd_data
  );
endinterface

// File: rtl/xalu_ctrl.sv
// Multiply/divide unit for the E stage: owns HI/LO, models fixed latency and
// raises busy towards the stall unit while an operation is in flight.
module xalu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic        clk,
  input logic        reset,
  xalu_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        res_we_q, res_we_d;

  logic        issue;
  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quo, rem;

  assign issue = bus.start & ~bus.req & (state_q == IDLE);

  assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to itself
  // with a zero remainder without a dedicated overflow case.
  assign div_signed = (bus.op == 3'd2);
  assign a_neg      = div_signed & bus.A[31];
  assign b_neg      = div_signed & bus.B[31];
  assign a_mag      = a_neg ? (~bus.A + 32'd1) : bus.A;
  assign b_mag      = b_neg ? (~bus.B + 32'd1) : bus.B;
  assign div_b      = (bus.B == '0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / div_b;
  assign r_mag      = a_mag % div_b;
  assign quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_we_d = res_we_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          unique case (bus.op)
            3'd0, 3'd1: begin
              {res_hi_d, res_lo_d} = (bus.op == 3'd0) ? prod_s : prod_u;
              res_we_d = 1'b1;
              cnt_d    = 4'(MUL_CYCLES);
              state_d  = BUSY;
            end
            3'd2, 3'd3: begin
              res_hi_d = rem;
              res_lo_d = quo;
              // Divide by zero still occupies the unit but leaves HI/LO alone.
              res_we_d = (bus.B != '0);
              cnt_d    = 4'(DIV_CYCLES);
              state_d  = BUSY;
            end
            3'd4:    hi_d = bus.A;
            3'd5:    lo_d = bus.A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (res_we_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_we_q <= res_we_d;
    end
  end

  assign bus.busy    = (state_q == BUSY);
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

endmodule
